// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the core load/store path and the DMA
// pixel loader. CPU has priority; a starvation counter guarantees the DMA a slot.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, WR, RD, WAIT, RESP} state_t;

  state_t            state, state_nx;
  logic              owner_dma, owner_dma_nx;
  logic [2:0]        wait_cnt, wait_cnt_nx;
  logic [3:0]        starve_cnt, starve_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] wdata_nx, cpu_rdata_nx, dma_rdata_nx;
  logic              cpu_req, dma_wins;

  assign cpu_req  = cpu_re | cpu_we;
  assign dma_wins = dma_req & (starve_cnt == 4'(STARVE_MAX));

  always_comb begin
    state_nx     = state;
    owner_dma_nx = owner_dma;
    wait_cnt_nx  = wait_cnt;
    starve_nx    = starve_cnt;
    addr_nx      = mem_addr;
    wdata_nx     = mem_wdata;
    cpu_rdata_nx = cpu_rdata;
    dma_rdata_nx = dma_rdata;
    case (state)
      IDLE: begin
        if (!dma_req) starve_nx = '0;
        if (cpu_req && !dma_wins) begin
          owner_dma_nx = 1'b0;
          addr_nx      = cpu_addr;
          wdata_nx     = cpu_wdata;
          state_nx     = cpu_we ? WR : RD;
          if (dma_req && starve_cnt != 4'(STARVE_MAX)) starve_nx = starve_cnt + 4'd1;
        end else if (dma_req) begin
          owner_dma_nx = 1'b1;
          addr_nx      = dma_addr;
          wdata_nx     = dma_wdata;
          state_nx     = dma_we ? WR : RD;
          starve_nx    = '0;
        end
      end
      WR: state_nx = IDLE;
      RD: begin
        wait_cnt_nx = 3'(RD_LAT);
        state_nx    = WAIT;
      end
      WAIT: begin
        wait_cnt_nx = wait_cnt - 3'd1;
        // Counter reaches 1 in the cycle RD_LAT after RD, when mem_rdata is valid.
        if (wait_cnt == 3'd1) begin
          if (owner_dma) dma_rdata_nx = mem_rdata;
          else           cpu_rdata_nx = mem_rdata;
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner_dma  <= 1'b0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      state      <= state_nx;
      owner_dma  <= owner_dma_nx;
      wait_cnt   <= wait_cnt_nx;
      starve_cnt <= starve_nx;
      mem_addr   <= addr_nx;
      mem_wdata  <= wdata_nx;
      cpu_rdata  <= cpu_rdata_nx;
      dma_rdata  <= dma_rdata_nx;
    end
  end

  assign mem_we    = (state == WR);
  assign mem_re    = (state == RD);
  assign cpu_done  = ((state == WR) || (state == RESP)) && !owner_dma;
  assign dma_done  = ((state == WR) || (state == RESP)) &&  owner_dma;
  assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed cycle-exact accesses, reset abort,
// starvation grant order and randomised back-to-back CPU/DMA traffic.
module tb_dmem_arbiter;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 4;

  logic        clk, rst_n;
  logic        cpu_re, cpu_we, cpu_stall, cpu_done;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_done;
  logic [15:0] dma_addr, dma_wdata, dma_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory with RD_LAT read latency; data is only valid in the exact return cycle.
  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [0:65535];
  int          cyc = 0, pend_cyc = -1;
  logic [15:0] pend_data = '0;
  always @(posedge clk) begin
    if (mem_re) begin
      pend_cyc  <= cyc + RD_LAT;
      pend_data <= mem[mem_addr];
    end
    if (mem_we) mem[mem_addr] <= mem_wdata;
    cyc <= cyc + 1;
  end
  assign mem_rdata = (cyc == pend_cyc) ? pend_data : 16'hDEAD;

  typedef struct {bit we; logic [15:0] addr; logic [15:0] data;} op_t;

  int          pass_cnt = 0, total_cnt = 0;
  logic [15:0] cpu_sb[$], dma_sb[$];
  logic [15:0] cpu_rd_model = '0, dma_rd_model = '0;
  bit          order_q[$];

  task automatic run_agent(input bit is_dma, input op_t ops[$]);
    bit          got;
    logic [15:0] exp;
    foreach (ops[i]) begin
      if (!ops[i].we) begin
        if (is_dma) dma_rd_model = ref_mem[ops[i].addr];
        else        cpu_rd_model = ref_mem[ops[i].addr];
      end else ref_mem[ops[i].addr] = ops[i].data;
      if (is_dma) begin
        dma_sb.push_back(dma_rd_model);
        dma_req = 1; dma_we = ops[i].we; dma_addr = ops[i].addr; dma_wdata = ops[i].data;
      end else begin
        cpu_sb.push_back(cpu_rd_model);
        cpu_we = ops[i].we; cpu_re = ops[i].we ? ops[i].data[0] : 1'b1;
        cpu_addr = ops[i].addr; cpu_wdata = ops[i].data;
      end
      got = 0;
      for (int c = 0; c < 60 && !got; c++) begin
        @(negedge clk);
        total_cnt++;
        if (mem_we && mem_re) $display("FAIL strobe_overlap: mem_we=%b mem_re=%b required not both 1", mem_we, mem_re);
        else pass_cnt++;
        got = is_dma ? dma_done : cpu_done;
      end
      total_cnt++;
      if (!got) begin
        $display("FAIL %s_done_timeout: got no done, required done within 60 cycles", is_dma ? "dma" : "cpu");
        cpu_re = 0; cpu_we = 0; dma_req = 0;
        return;
      end
      pass_cnt++;
      order_q.push_back(is_dma);
      exp = is_dma ? dma_sb.pop_front() : cpu_sb.pop_front();
      total_cnt++;
      if ((is_dma ? dma_rdata : cpu_rdata) !== exp)
        $display("FAIL %s_rdata op%0d: got %h required %h", is_dma ? "dma" : "cpu", i,
                 is_dma ? dma_rdata : cpu_rdata, exp);
      else pass_cnt++;
    end
    if (is_dma) dma_req = 0;
    else begin cpu_re = 0; cpu_we = 0; end
  endtask

  task automatic test_reset();
    logic [72:0] v;
    #1;
    v = {mem_we, mem_re, cpu_done, dma_done, cpu_stall, mem_addr, mem_wdata, cpu_rdata, dma_rdata};
    total_cnt++;
    if (v !== '0) $display("FAIL reset_outputs: got %h required 0", v); else pass_cnt++;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    total_cnt++;
    if ({mem_we, mem_re, cpu_done, dma_done} !== 4'b0)
      $display("FAIL reset_idle: got %b required 0000", {mem_we, mem_re, cpu_done, dma_done});
    else pass_cnt++;
  endtask

  task automatic test_store();
    cpu_we = 1; cpu_re = 0; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
    ref_mem[16'h0010] = 16'hBEEF;
    cpu_sb.push_back(cpu_rd_model);
    #1;
    total_cnt++;
    if ({cpu_stall, mem_we, cpu_done} !== 3'b100)
      $display("FAIL store_seen: stall/we/done got %b required 100", {cpu_stall, mem_we, cpu_done});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({mem_we, mem_re, cpu_done, cpu_stall, mem_addr, mem_wdata} !== {4'b1010, 16'h0010, 16'hBEEF})
      $display("FAIL store_wr: we/re/done/stall/addr/wdata got %b %b %b %b %h %h required 1 0 1 0 0010 beef",
               mem_we, mem_re, cpu_done, cpu_stall, mem_addr, mem_wdata);
    else pass_cnt++;
    total_cnt++;
    if (cpu_rdata !== cpu_sb.pop_front()) $display("FAIL store_rdata: got %h required unchanged", cpu_rdata);
    else pass_cnt++;
    cpu_we = 0;
    @(negedge clk);
    total_cnt++;
    if ({mem_we, cpu_done, cpu_stall} !== 3'b000)
      $display("FAIL store_after: we/done/stall got %b required 000", {mem_we, cpu_done, cpu_stall});
    else pass_cnt++;
  endtask

  task automatic test_load();
    cpu_re = 1; cpu_we = 0; cpu_addr = 16'h0010;
    cpu_rd_model = ref_mem[16'h0010];
    cpu_sb.push_back(cpu_rd_model);
    for (int k = 1; k <= RD_LAT + 2; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({mem_re, cpu_done, cpu_stall} !== {k == 1, k == RD_LAT + 2, k != RD_LAT + 2})
        $display("FAIL load_cycle%0d: re/done/stall got %b required %b", k, {mem_re, cpu_done, cpu_stall},
                 {k == 1, k == RD_LAT + 2, k != RD_LAT + 2});
      else pass_cnt++;
      if (k == 1) begin
        total_cnt++;
        if (mem_addr !== 16'h0010) $display("FAIL load_addr: got %h required 0010", mem_addr); else pass_cnt++;
      end
    end
    total_cnt++;
    if ({cpu_rdata, dma_rdata} !== {cpu_sb.pop_front(), dma_rd_model})
      $display("FAIL load_rdata: cpu/dma got %h %h required beef %h", cpu_rdata, dma_rdata, dma_rd_model);
    else pass_cnt++;
    cpu_re = 0;
    @(negedge clk);
  endtask

  task automatic test_dma_read();
    dma_req = 1; dma_we = 0; dma_addr = 16'h0200;
    dma_rd_model = ref_mem[16'h0200];
    dma_sb.push_back(dma_rd_model);
    for (int k = 1; k <= RD_LAT + 2; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({dma_done, cpu_done, cpu_stall} !== {k == RD_LAT + 2, 2'b00})
        $display("FAIL dma_cycle%0d: dma_done/cpu_done/stall got %b required %b", k,
                 {dma_done, cpu_done, cpu_stall}, {k == RD_LAT + 2, 2'b00});
      else pass_cnt++;
    end
    total_cnt++;
    if ({dma_rdata, cpu_rdata} !== {dma_sb.pop_front(), cpu_rd_model})
      $display("FAIL dma_rdata: dma/cpu got %h %h required 1234 %h", dma_rdata, cpu_rdata, cpu_rd_model);
    else pass_cnt++;
    dma_req = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_midread();
    logic [72:0] v;
    cpu_re = 1; cpu_we = 0; cpu_addr = 16'h0300;
    repeat (2) @(negedge clk);
    rst_n = 0; cpu_re = 0;
    cpu_rd_model = '0; dma_rd_model = '0;
    #1;
    v = {mem_we, mem_re, cpu_done, dma_done, cpu_stall, mem_addr, mem_wdata, cpu_rdata, dma_rdata};
    total_cnt++;
    if (v !== '0) $display("FAIL midread_reset: got %h required 0", v); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({cpu_done, dma_done, mem_re, mem_we} !== 4'b0)
        $display("FAIL midread_no_done%0d: done/re/we got %b required 0000", k, {cpu_done, dma_done, mem_re, mem_we});
      else pass_cnt++;
    end
  endtask

  task automatic test_starve();
    op_t  c[$], d[$];
    bit   exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      c.push_back('{1'b1, 16'h0400 + 16'(i), 16'hA000 + 16'(i)});
      c.push_back('{1'b0, 16'h0400 + 16'(i), 16'h0000});
    end
    d.push_back('{1'b1, 16'h0500, 16'h5A5A});
    d.push_back('{1'b0, 16'h0500, 16'h0000});
    order_q.delete();
    fork
      run_agent(1'b0, c);
      run_agent(1'b1, d);
    join
    total_cnt++;
    if (order_q.size() != 10) $display("FAIL starve_count: got %0d grants required 10", order_q.size());
    else pass_cnt++;
    for (int i = 0; i < 10 && i < order_q.size(); i++) begin
      total_cnt++;
      if (order_q[i] !== exp_order[i]) $display("FAIL starve_order%0d: got dma=%b required dma=%b", i, order_q[i], exp_order[i]);
      else pass_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    op_t c[$], d[$];
    for (int i = 0; i < 14; i++)
      c.push_back('{1'($urandom_range(0, 1)), 16'h1000 + 16'($urandom_range(0, 3)), 16'($urandom)});
    for (int i = 0; i < 6; i++)
      d.push_back('{1'($urandom_range(0, 1)), 16'h2000 + 16'($urandom_range(0, 3)), 16'($urandom)});
    fork
      run_agent(1'b0, c);
      run_agent(1'b1, d);
    join
    total_cnt++;
    if (cpu_sb.size() + dma_sb.size() != 0)
      $display("FAIL scoreboard_drain: got %0d pending required 0", cpu_sb.size() + dma_sb.size());
    else pass_cnt++;
  endtask

  initial begin
    clk = 0; rst_n = 0;
    cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'(i * 7 + 3);
      ref_mem[i] = mem[i];
    end
    mem[16'h0200] = 16'h1234; ref_mem[16'h0200] = 16'h1234;
    test_reset();
    test_store();
    test_load();
    test_dma_read();
    test_reset_midread();
    test_starve();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
